// File: rtl/sram_1w1r_clr.sv
// -----------------------------------------------------------------------------
// sram_1w1r_clr
//
// Purpose
//   Single-clock SRAM with one write port, one read port and a sequential
//   whole-array clear. The array has no reset of its own. Zeroing is done
//   only by a CLEAR sweep that writes one word per cycle from address 0 up
//   to DEPTH-1. The sweep starts after every reset and after every clr_i
//   request that arrives while idle. Read and write accesses are ignored
//   while the sweep runs.
//
// Configuration macro
//   SRAM_BYPASS_EN  defined   : a same-cycle read and write to one address
//                               returns wdata_i (write-first forwarding).
//                   undefined : the same case returns the previously stored
//                               word (read-first). The array is written in
//                               both builds.
//
// Parameters
//   DW  data word width in bits (default 24)
//   AW  address width; DEPTH = 2**AW words (default 11 -> 2048 words)
//
// Ports
//   clk_i     in   1   clock; all state changes on the rising edge
//   rst_i     in   1   synchronous active-low reset
//   wr_en_i   in   1   write strobe
//   waddr_i   in   AW  write address
//   wdata_i   in   DW  write data
//   rd_en_i   in   1   read strobe
//   raddr_i   in   AW  read address
//   clr_i     in   1   one-cycle request to zero the whole array
//   rdata_o   out  DW  registered read data; holds when no read completes
//   rvalid_o  out  1   one-cycle pulse that marks fresh rdata_o
//   busy_o    out  1   clear sweep in progress; accesses are ignored
// -----------------------------------------------------------------------------
module sram_1w1r_clr #(
    parameter int DW = 24,
    parameter int AW = 11
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] raddr_i,
    input  logic          clr_i,
    output logic [DW-1:0] rdata_o,
    output logic          rvalid_o,
    output logic          busy_o
);

    localparam int DEPTH = 2 ** AW;

    // The last sweep address is DEPTH-1, which is all ones.
    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] CNT_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Storage and state
    logic [DW-1:0] mem_q [DEPTH];

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] clr_cnt_q;
    logic [AW-1:0] clr_cnt_d;
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;
    logic          rvalid_q;
    logic          rvalid_d;

    // Array write port, shared by user writes and the clear sweep
    logic          mem_we_s;
    logic [AW-1:0] mem_waddr_s;
    logic [DW-1:0] mem_wdata_s;

    // Word presented to the read register
    logic [DW-1:0] rd_word_s;
    logic          same_addr_s;

    // Outputs
    assign busy_o   = (state_q == ST_CLEAR);
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

    // Detect a same-cycle write to the address being read.
    always_comb begin
        if (wr_en_i && (waddr_i == raddr_i)) begin
            same_addr_s = 1'b1;
        end else begin
            same_addr_s = 1'b0;
        end
    end

    // Select the read word. This is the forwarding path or a plain array read.
    always_comb begin
`ifdef SRAM_BYPASS_EN
        // Write-first. The incoming write data wins over the stored word.
        if (same_addr_s) begin
            rd_word_s = wdata_i;
        end else begin
            rd_word_s = mem_q[raddr_i];
        end
`else
        // Read-first. The array is read before this edge's write lands.
        if (same_addr_s) begin
            rd_word_s = mem_q[raddr_i];
        end else begin
            rd_word_s = mem_q[raddr_i];
        end
`endif
    end

    // Next-state logic for the FSM, the sweep counter, the read register
    // and the array write port.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        mem_we_s    = 1'b0;
        mem_waddr_s = waddr_i;
        mem_wdata_s = wdata_i;

        case (state_q)
            ST_IDLE: begin
                // A clear request does not cancel accesses made in the same cycle.
                if (clr_i) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = CNT_ZERO;
                end else begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = clr_cnt_q;
                end

                if (wr_en_i) begin
                    mem_we_s    = 1'b1;
                    mem_waddr_s = waddr_i;
                    mem_wdata_s = wdata_i;
                end else begin
                    mem_we_s    = 1'b0;
                end

                if (rd_en_i) begin
                    rdata_d  = rd_word_s;
                    rvalid_d = 1'b1;
                end else begin
                    rdata_d  = rdata_q;
                    rvalid_d = 1'b0;
                end
            end

            ST_CLEAR: begin
                // One word per cycle. clr_i, wr_en_i and rd_en_i are ignored.
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_cnt_q;
                mem_wdata_s = DATA_ZERO;
                rdata_d     = rdata_q;
                rvalid_d    = 1'b0;
                if (clr_cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = CNT_ZERO;
                end else begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = clr_cnt_q + CNT_ONE;
                end
            end

            default: begin
                // An unreachable encoding recovers by sweeping the array again.
                state_d   = ST_CLEAR;
                clr_cnt_d = CNT_ZERO;
                rdata_d   = rdata_q;
                rvalid_d  = 1'b0;
                mem_we_s  = 1'b0;
            end
        endcase
    end

    // FSM state, sweep counter and registered read outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= CNT_ZERO;
            rdata_q   <= DATA_ZERO;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Array write. There is no per-word reset. Writes are blocked while
    // rst_i is low, so the sweep alone zeroes the array after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i && mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

endmodule

// File: tb/tb_sram_1w1r_clr.sv
module tb_sram_1w1r_clr;

    localparam int DW = 24;
    localparam int AW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          wr_en_i;
    logic [AW-1:0] waddr_i;
    logic [DW-1:0] wdata_i;
    logic          rd_en_i;
    logic [AW-1:0] raddr_i;
    logic          clr_i;
    logic [DW-1:0] rdata_o;
    logic          rvalid_o;
    logic          busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    sram_1w1r_clr #(.DW(DW), .AW(AW)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wr_en_i  (wr_en_i),
        .waddr_i  (waddr_i),
        .wdata_i  (wdata_i),
        .rd_en_i  (rd_en_i),
        .raddr_i  (raddr_i),
        .clr_i    (clr_i),
        .rdata_o  (rdata_o),
        .rvalid_o (rvalid_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        wr_en_i = 1'b0;
        rd_en_i = 1'b0;
        clr_i   = 1'b0;
    endtask

    // Count the edges until busy_o falls. The count is bounded.
    task automatic wait_clear(input string tag);
        int n = 0;
        while (busy_o === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(n), 32'd16);
    endtask

    // Read all 16 addresses back to back. Each read must return zero.
    task automatic read_all_zero(input string tag);
        for (int a = 0; a < 16; a++) begin
            rd_en_i = 1'b1;
            raddr_i = AW'(a);
            tick();
            check_eq({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
            check_eq({tag, "_data"}, 32'(rdata_o), 32'h0);
        end
        rd_en_i = 1'b0;
        tick();
        check_eq({tag, "_rvalid_end"}, 32'(rvalid_o), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] exp_same;
`ifdef SRAM_BYPASS_EN
        exp_same = 24'h222222;
`else
        exp_same = 24'h111111;
`endif
        rst_i   = 1'b0;
        waddr_i = '0;
        raddr_i = '0;
        wdata_i = '0;
        quiet();

        // Reset is held for two edges, then released.
        tick();
        check_eq("rst_busy", 32'(busy_o), 32'd1);
        check_eq("rst_rvalid", 32'(rvalid_o), 32'd0);
        check_eq("rst_rdata", 32'(rdata_o), 32'h0);
        tick();
        rst_i = 1'b1;
        wait_clear("rst_clear_len");
        read_all_zero("init_zero");

        // Write address 5, then read it on the next cycle.
        wr_en_i = 1'b1; waddr_i = 4'd5; wdata_i = 24'hABCDEF;
        tick();
        wr_en_i = 1'b0; rd_en_i = 1'b1; raddr_i = 4'd5;
        tick();
        check_eq("wr_rd5_data", 32'(rdata_o), 32'hABCDEF);
        check_eq("wr_rd5_rvalid", 32'(rvalid_o), 32'd1);
        rd_en_i = 1'b0;
        tick();
        check_eq("rvalid_pulse", 32'(rvalid_o), 32'd0);
        check_eq("rdata_hold", 32'(rdata_o), 32'hABCDEF);

        // Same-address read and write in one cycle.
        wr_en_i = 1'b1; waddr_i = 4'd3; wdata_i = 24'h111111;
        tick();
        wr_en_i = 1'b1; waddr_i = 4'd3; wdata_i = 24'h222222;
        rd_en_i = 1'b1; raddr_i = 4'd3;
        tick();
        check_eq("same_addr", 32'(rdata_o), 32'(exp_same));
        wr_en_i = 1'b0;
        tick();
        check_eq("same_addr_after", 32'(rdata_o), 32'h222222);

        // Read and write to different addresses in one cycle.
        wr_en_i = 1'b1; waddr_i = 4'd7; wdata_i = 24'h777777;
        rd_en_i = 1'b1; raddr_i = 4'd5;
        tick();
        check_eq("diff_addr_rd", 32'(rdata_o), 32'hABCDEF);
        wr_en_i = 1'b0; raddr_i = 4'd7;
        tick();
        check_eq("diff_addr_wr", 32'(rdata_o), 32'h777777);
        rd_en_i = 1'b0;

        // Fill the array with non-zero data.
        for (int a = 0; a < 16; a++) begin
            wr_en_i = 1'b1; waddr_i = AW'(a); wdata_i = 24'hA50000 + 24'(a);
            tick();
        end
        wr_en_i = 1'b0;

        // Read back to back. rvalid_o must stay high with data in address order.
        for (int a = 0; a < 16; a++) begin
            rd_en_i = 1'b1; raddr_i = AW'(a);
            tick();
            check_eq("b2b_rvalid", 32'(rvalid_o), 32'd1);
            check_eq("b2b_data", 32'(rdata_o), 32'hA50000 + 32'(a));
        end
        rd_en_i = 1'b0;

        // A clear request with a read and a write in the same cycle.
        // Both accesses still execute.
        clr_i = 1'b1;
        wr_en_i = 1'b1; waddr_i = 4'd2; wdata_i = 24'h123456;
        rd_en_i = 1'b1; raddr_i = 4'd4;
        tick();
        check_eq("clr_busy", 32'(busy_o), 32'd1);
        check_eq("clr_same_rd", 32'(rdata_o), 32'hA50004);
        check_eq("clr_same_rv", 32'(rvalid_o), 32'd1);

        // Accesses and repeated clr_i during the sweep must be ignored.
        wr_en_i = 1'b1; waddr_i = 4'd9; wdata_i = 24'hFFFFFF;
        rd_en_i = 1'b1; raddr_i = 4'd9; clr_i = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            check_eq("clr_busy_hold", 32'(busy_o), 32'd1);
            check_eq("clr_rvalid0", 32'(rvalid_o), 32'd0);
            check_eq("clr_rdata_hold", 32'(rdata_o), 32'hA50004);
        end
        tick();
        check_eq("clr_done", 32'(busy_o), 32'd0);
        check_eq("clr_done_rv", 32'(rvalid_o), 32'd0);
        quiet();
        read_all_zero("after_clr");

        // Reset during a clear restarts the sweep and drops a pending read.
        wr_en_i = 1'b1; waddr_i = 4'd0; wdata_i = 24'h0000AA;
        tick();
        wr_en_i = 1'b0; clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        rst_i = 1'b0; rd_en_i = 1'b1; raddr_i = 4'd0;
        tick();
        check_eq("midrst_busy", 32'(busy_o), 32'd1);
        check_eq("midrst_rvalid", 32'(rvalid_o), 32'd0);
        check_eq("midrst_rdata", 32'(rdata_o), 32'h0);
        rst_i = 1'b1; rd_en_i = 1'b0;
        wait_clear("midrst_clear_len");

        // Reset during a read drops the read.
        rd_en_i = 1'b1; raddr_i = 4'd5; rst_i = 1'b0;
        tick();
        check_eq("rdrst_rvalid", 32'(rvalid_o), 32'd0);
        check_eq("rdrst_busy", 32'(busy_o), 32'd1);
        rst_i = 1'b1; rd_en_i = 1'b0;
        wait_clear("rdrst_clear_len");
        read_all_zero("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_1w1r_clr.md
SRAM_1W1R_CLR -- requirements
Module: sram_1w1r_clr

Interface
REQ-001 Parameter DW, default 24, data word width in bits.
REQ-002 Parameter AW, default 11, address width; DEPTH = 2**AW words (2048 by default).
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-low, sampled on the clk_i rising edge.
REQ-005 wr_en_i  input  1  write strobe; writes wdata_i to waddr_i.
REQ-006 waddr_i  input  AW  write address.
REQ-007 wdata_i  input  DW  write data.
REQ-008 rd_en_i  input  1  read strobe; reads from raddr_i.
REQ-009 raddr_i  input  AW  read address, independent of waddr_i.
REQ-010 clr_i  input  1  one-cycle request to zero the whole array.
REQ-011 rdata_o  output  DW  registered read data.
REQ-012 rvalid_o  output  1  one-cycle pulse; rdata_o carries fresh read data.
REQ-013 busy_o  output  1  array clear in progress; all accesses are ignored while high.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and CLEAR; busy_o = (state == CLEAR), decoded combinationally from state.
REQ-015 In CLEAR, the block SHALL write zero to address clr_cnt on each cycle and increment clr_cnt from 0 to DEPTH-1; after writing DEPTH-1 it SHALL go to IDLE, so a clear takes exactly DEPTH cycles.
REQ-016 In IDLE, clr_i=1 SHALL move the FSM to CLEAR with clr_cnt=0 on the next edge; wr_en_i and rd_en_i asserted in that same cycle SHALL still execute.
REQ-017 clr_i in CLEAR SHALL be ignored; the running clear SHALL neither restart nor extend.
REQ-018 In IDLE, wr_en_i=1 SHALL store wdata_i at waddr_i on the same edge.
REQ-019 In IDLE, rd_en_i=1 SHALL load mem[raddr_i] into rdata_o and set rvalid_o=1 on the next edge (1-cycle latency); rvalid_o SHALL otherwise be 0.
REQ-020 rdata_o SHALL hold its last value when no read completes, including throughout CLEAR.
REQ-021 In CLEAR, wr_en_i and rd_en_i SHALL be ignored: no array write, no rdata_o update, rvalid_o=0.
REQ-022 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-023 Simultaneous read and write to the same address SHALL follow REQ-035/REQ-036.
REQ-024 Back-to-back reads SHALL sustain one result per cycle, with rvalid_o held high continuously.

Reset
REQ-025 When rst_i=0 at an edge: state SHALL become CLEAR, clr_cnt=0, rdata_o=0 and rvalid_o=0.
REQ-026 busy_o SHALL be 1 from the first reset edge onward.
REQ-027 For release before edge N, edges N..N+DEPTH-1 SHALL clear addresses 0..DEPTH-1; busy_o SHALL be 0 after edge N+DEPTH-1.
REQ-028 Reset asserted mid-clear or mid-read SHALL restart the clear at address 0 and drop any pending rvalid_o.
REQ-029 The array SHALL NOT use a per-word parallel reset; zeroing is performed only by the CLEAR sweep.

Configuration
REQ-035 Macro SRAM_BYPASS_EN defined: a same-cycle read and write to one address SHALL return wdata_i on rdata_o (write-first forwarding).
REQ-036 SRAM_BYPASS_EN undefined: the same case SHALL return the word stored before the write (read-first); the array SHALL be updated in both builds.

Verification (DW=24, AW=4, DEPTH=16)
REQ-040 Hold rst_i=0 for 2 cycles, then release -> busy_o=1 for exactly 16 cycles then 0; reading all 16 addresses returns 0x000000.
REQ-041 Write 0xABCDEF to address 5, then read address 5 on the next cycle -> one cycle later rdata_o=0xABCDEF and rvalid_o=1 for 1 cycle.
REQ-042 Address 3 holds 0x111111; same cycle: write 0x222222 to 3 and read 3 -> rdata_o=0x222222 with SRAM_BYPASS_EN, 0x111111 without; a following read returns 0x222222 in both builds.
REQ-043 Fill all addresses with non-zero data, pulse clr_i, then issue writes and reads during busy_o=1 -> rvalid_o stays 0, rdata_o is unchanged; after busy_o falls, every address reads 0.
REQ-044 Assert rst_i=0 at clear cycle 7 -> clear restarts at 0; busy_o stays high 16 cycles after release; pending rvalid_o is dropped.
REQ-045 Assert rd_en_i for 16 consecutive cycles over addresses 0..15 -> rvalid_o high for 16 consecutive cycles with data in address order.
